// File: rtl/pulse_train_pkg.sv
// Shared types and defaults for the pulse train generator.
// The state encoding is fixed at 2 bits so that it stays stable across tools.
package pulse_train_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        PT_IDLE = 2'd0,
        PT_HIGH = 2'd1,
        PT_LOW  = 2'd2,
        PT_DONE = 2'd3
    } pt_state_t;

endpackage

// File: rtl/load_down_cnt.sv
// Loadable down-counter that saturates at zero.
// zero_o reports whether the current count is zero.
module load_down_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // NOTE: sequential state is updated with <= only, so every flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Generates COUNT pulses of programmable high/low length on a registered wave_o.
// Rise/fall strobes are aligned to each edge; done_o is a strobe on normal completion.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [CNT_W-1:0] high_len_i,
    input  logic [CNT_W-1:0] low_len_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             wave_o,
    output logic             rise_o,
    output logic             fall_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    pt_state_t        state_d, state_q;
    logic             wave_d, wave_q;
    logic             rise_d, rise_q;
    logic             fall_d, fall_q;
    logic             done_d, done_q;
    logic [CNT_W-1:0] high_m1_d, high_m1_q;
    logic [CNT_W-1:0] low_m1_d, low_m1_q;

    logic             ph_load, ph_zero;
    logic [CNT_W-1:0] ph_val;
    logic             pc_load, pc_en, pc_zero;
    logic             busy;

    assign busy = (state_q == PT_HIGH) || (state_q == PT_LOW);

    // Phase lengths are stored as len-1, with 0 clamped to 1, so the maximum length needs no extra bit.
    always_comb begin
        state_d   = state_q;
        wave_d    = wave_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        done_d    = 1'b0;
        high_m1_d = high_m1_q;
        low_m1_d  = low_m1_q;
        ph_load   = 1'b0;
        ph_val    = '0;
        pc_load   = 1'b0;
        pc_en     = 1'b0;

        case (state_q)
            PT_HIGH: begin
                if (abort_i) begin
                    state_d = PT_IDLE;
                    wave_d  = 1'b0;
                    fall_d  = 1'b1;
                end else if (ph_zero) begin
                    state_d = PT_LOW;
                    wave_d  = 1'b0;
                    fall_d  = 1'b1;
                    ph_load = 1'b1;
                    ph_val  = low_m1_q;
                    pc_en   = 1'b1;
                end
            end
            PT_LOW: begin
                if (abort_i) begin
                    state_d = PT_IDLE;
                    wave_d  = 1'b0;
                end else if (ph_zero) begin
                    if (pc_zero) begin
                        state_d = PT_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PT_HIGH;
                        wave_d  = 1'b1;
                        rise_d  = 1'b1;
                        ph_load = 1'b1;
                        ph_val  = high_m1_q;
                    end
                end
            end
            default: begin
                // IDLE and DONE both accept a new train.
                wave_d = 1'b0;
                if (state_q == PT_DONE) begin
                    state_d = PT_IDLE;
                end
                if (start_i && !abort_i) begin
                    high_m1_d = (high_len_i == '0) ? '0 : high_len_i - ONE;
                    low_m1_d  = (low_len_i == '0) ? '0 : low_len_i - ONE;
                    if (count_i != '0) begin
                        state_d = PT_HIGH;
                        wave_d  = 1'b1;
                        rise_d  = 1'b1;
                        ph_load = 1'b1;
                        ph_val  = high_m1_d;
                        pc_load = 1'b1;
                    end else begin
                        state_d = PT_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PT_IDLE;
            wave_q    <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            done_q    <= 1'b0;
            high_m1_q <= '0;
            low_m1_q  <= '0;
        end else begin
            state_q   <= state_d;
            wave_q    <= wave_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            done_q    <= done_d;
            high_m1_q <= high_m1_d;
            low_m1_q  <= low_m1_d;
        end
    end

    load_down_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (ph_load),
        .load_val (ph_val),
        .en       (busy),
        .zero_o   (ph_zero)
    );

    load_down_cnt #(.CNT_W(CNT_W)) u_pulse_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .load_val (count_i),
        .en       (pc_en),
        .zero_o   (pc_zero)
    );

    assign busy_o = busy;
    assign done_o = done_q;
    assign wave_o = wave_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based model that expands each accepted train into its per-cycle waveform.
module tb_pulse_train_gen;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_i;
    logic [W-1:0] high_len_i;
    logic [W-1:0] low_len_i;
    logic [W-1:0] count_i;
    logic         abort_i;
    logic         busy_o, done_o, wave_o, rise_o, fall_o;

    int n_checks = 0;
    int n_errors = 0;

    pulse_train_gen #(.CNT_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .high_len_i (high_len_i),
        .low_len_i  (low_len_i),
        .count_i    (count_i),
        .abort_i    (abort_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .wave_o     (wave_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o)
    );

    always #5 clk = ~clk;

    // Model: each future cycle is an entry {wave, busy, done}; strobes come from edges.
    logic [2:0] exp_q[$];
    logic       m_wave = 1'b0;
    logic       m_busy = 1'b0;
    logic [4:0] exp_o;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s @%0t: got {busy,done,wave,rise,fall}=%b expected %b",
                     tag, $time, got, want);
        end
    endtask

    task automatic model_step(input logic st, input logic ab, input logic rs,
                              input logic [W-1:0] h, input logic [W-1:0] l,
                              input logic [W-1:0] c);
        logic [2:0] nx;
        logic       fall_ok;
        int         hh, ll;
        fall_ok = 1'b1;
        if (rs) begin
            exp_q.delete();
            nx      = 3'b000;
            fall_ok = 1'b0;
        end else if (m_busy && ab) begin
            exp_q.delete();
            nx = 3'b000;
        end else if (!m_busy && st && !ab) begin
            exp_q.delete();
            hh = (h == 0) ? 1 : int'(h);
            ll = (l == 0) ? 1 : int'(l);
            for (int p = 0; p < int'(c); p++) begin
                for (int k = 0; k < hh; k++) exp_q.push_back(3'b110);
                for (int k = 0; k < ll; k++) exp_q.push_back(3'b010);
            end
            exp_q.push_back(3'b001);
            nx = exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            nx = exp_q.pop_front();
        end else begin
            nx = 3'b000;
        end
        exp_o  = {nx[1], nx[0], nx[2], nx[2] & ~m_wave, ~nx[2] & m_wave & fall_ok};
        m_wave = nx[2];
        m_busy = nx[1];
    endtask

    // Applies one cycle of inputs, advances the model, and checks outputs #1 after the edge.
    task automatic step(input logic st, input logic ab, input logic rs,
                        input logic [W-1:0] h, input logic [W-1:0] l,
                        input logic [W-1:0] c, input string tag);
        start_i    = st;
        abort_i    = ab;
        reset      = rs;
        high_len_i = h;
        low_len_i  = l;
        count_i    = c;
        model_step(st, ab, rs, h, l, c);
        @(posedge clk);
        #1;
        check(tag, {busy_o, done_o, wave_o, rise_o, fall_o}, exp_o);
    endtask

    // Idle cycles with scrambled config inputs, which must have no effect.
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b0, W'($urandom_range(0, 63)), W'($urandom_range(0, 63)),
                 W'($urandom_range(0, 63)), tag);
        end
    endtask

    logic         r_st, r_ab, r_rs;
    logic [W-1:0] r_h, r_l, r_c;

    initial begin
        start_i = 1'b0; abort_i = 1'b0; reset = 1'b1;
        high_len_i = '0; low_len_i = '0; count_i = '0;

        step(1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 6'd0, "reset");
        step(1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 6'd0, "reset");
        idle(2, "after_reset");

        step(1'b1, 1'b0, 1'b0, 6'd3, 6'd2, 6'd2, "basic_start");
        idle(12, "basic");

        step(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd3, "zero_len_start");
        idle(8, "zero_len");
        step(1'b1, 1'b0, 1'b0, 6'd4, 6'd4, 6'd0, "zero_count_start");
        idle(3, "zero_count");

        step(1'b1, 1'b0, 1'b0, 6'd5, 6'd5, 6'd4, "abort_start");
        idle(2, "abort_high");
        step(1'b0, 1'b1, 1'b0, 6'd5, 6'd5, 6'd4, "abort_hit");
        idle(6, "abort_after");

        step(1'b1, 1'b0, 1'b0, 6'd5, 6'd5, 6'd4, "abort_st_start");
        idle(2, "abort_st_high");
        step(1'b1, 1'b1, 1'b0, 6'd5, 6'd5, 6'd4, "abort_with_start");
        idle(6, "abort_st_after");

        step(1'b1, 1'b0, 1'b0, 6'd2, 6'd4, 6'd2, "abort_low_start");
        idle(3, "abort_low_run");
        step(1'b0, 1'b1, 1'b0, 6'd2, 6'd4, 6'd2, "abort_in_low");
        idle(4, "abort_low_after");

        step(1'b0, 1'b1, 1'b0, 6'd2, 6'd2, 6'd2, "abort_idle");
        step(1'b1, 1'b1, 1'b0, 6'd2, 6'd2, 6'd2, "abort_blocks_start");
        idle(2, "abort_idle_after");

        for (int i = 0; i < 13; i++) begin
            step(1'b1, 1'b0, 1'b0, 6'd1, 6'd1, 6'd1, "back_to_back");
        end
        idle(3, "b2b_after");

        step(1'b1, 1'b0, 1'b0, 6'd4, 6'd2, 6'd1, "rst_mid_start");
        idle(1, "rst_mid_high");
        step(1'b0, 1'b0, 1'b1, 6'd4, 6'd2, 6'd1, "rst_mid_hit");
        step(1'b1, 1'b0, 1'b0, 6'd3, 6'd2, 6'd2, "rst_fresh_start");
        idle(12, "rst_fresh");

        step(1'b1, 1'b0, 1'b0, 6'd3, 6'd2, 6'd3, "latch_start");
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 6'd7, 6'd6, 6'd9, "latch_hold");
        end
        step(1'b0, 1'b0, 1'b0, 6'd7, 6'd6, 6'd9, "latch_tail");
        idle(4, "latch_after");

        step(1'b1, 1'b0, 1'b0, 6'd63, 6'd63, 6'd2, "max_len_start");
        idle(256, "max_len");
        step(1'b1, 1'b0, 1'b0, 6'd1, 6'd1, 6'd63, "max_count_start");
        idle(192, "max_count");

        for (int i = 0; i < 2000; i++) begin
            r_st = ($urandom_range(0, 3) == 0);
            r_ab = ($urandom_range(0, 39) == 0);
            r_rs = ($urandom_range(0, 299) == 0);
            r_h  = W'($urandom_range(0, 7));
            r_l  = W'($urandom_range(0, 7));
            r_c  = W'($urandom_range(0, 4));
            step(r_st, r_ab, r_rs, r_h, r_l, r_c, "random");
        end
        idle(80, "drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
